// File: rtl/io_port_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : io_port_decoder
//  Description : Port-address decoder and read multiplexer between the KCPSM6
//                port bus and NCH peripheral channels. Produces registered
//                per-channel read/write pulses, a held activity flag per
//                channel, and a saturating count of unmapped accesses that is
//                readable (and clearable) through a status port address.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1        system clock, rising edge
//    reset_n       in   1        asynchronous active-low reset
//    port_id       in   AW       KCPSM6 port address
//    out_port      in   DW       KCPSM6 write data
//    write_strobe  in   1        KCPSM6 write strobe (one cycle)
//    read_strobe   in   1        KCPSM6 read strobe (one cycle)
//    in_port       out  DW       registered read data to KCPSM6
//    ch_rdata      in   NCH*DW   channel read buses, channel i at [i*DW +: DW]
//    ch_wr         out  NCH      registered one-cycle write pulse per channel
//    ch_rd         out  NCH      registered one-cycle read pulse per channel
//    ch_wdata      out  DW       write data captured on any mapped write
//    dir           out  SPAN_LOG2 local offset of the last mapped access
//    act           out  NCH      per-channel activity flag (held ACT_HOLD cycles)
//    miss_cnt      out  8        saturating count of unmapped accesses
// ============================================================================
module io_port_decoder #(
    parameter int                DW        = 8,
    parameter int                AW        = 8,
    parameter int                NCH       = 4,
    parameter int                SPAN_LOG2 = 4,
    parameter logic [AW-1:0]     BASE_ADDR = 8'h00,
    parameter logic [AW-1:0]     STAT_ADDR = 8'hFF,
    parameter int                ACT_HOLD  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [AW-1:0]         port_id,
    input  logic [DW-1:0]         out_port,
    input  logic                  write_strobe,
    input  logic                  read_strobe,
    output logic [DW-1:0]         in_port,
    input  logic [NCH*DW-1:0]     ch_rdata,
    output logic [NCH-1:0]        ch_wr,
    output logic [NCH-1:0]        ch_rd,
    output logic [DW-1:0]         ch_wdata,
    output logic [SPAN_LOG2-1:0]  dir,
    output logic [NCH-1:0]        act,
    output logic [7:0]            miss_cnt
);

    // Window size and activity reload value.
    localparam logic [31:0] c_SPAN    = 32'd1 << SPAN_LOG2;
    localparam logic [7:0]  c_HOLD_LD = 8'(ACT_HOLD - 1);
    localparam logic [7:0]  c_MISS_MAX = 8'hFF;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic [NCH-1:0] w_hit;

    // The offset from each window base is taken in 33 bits; a port_id below
    // the base shows up as a set bit 32, so no window can wrap around the top
    // of the address space. Windows that run past 2^AW are naturally cut off
    // because port_id can never exceed 2^AW-1.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_decode
        localparam logic [32:0] c_LO = 33'(BASE_ADDR) + (33'(gi) << SPAN_LOG2);
        logic [32:0] w_diff;

        assign w_diff    = 33'(port_id) - c_LO;
        assign w_hit[gi] = !w_diff[32] && (w_diff[31:0] < c_SPAN);
    end

    logic w_any_hit;
    logic w_is_stat;
    logic w_any_strobe;
    logic w_wr;
    logic w_rd;

    assign w_any_hit    = |w_hit;
    assign w_is_stat    = (port_id == STAT_ADDR);
    assign w_any_strobe = write_strobe | read_strobe;
    // A write wins over a simultaneous read; the read is dropped entirely.
    assign w_wr         = write_strobe;
    assign w_rd         = read_strobe & ~write_strobe;

    // Offset within the window. Windows are aligned to BASE_ADDR, so the low
    // SPAN_LOG2 bits of (port_id - BASE_ADDR) equal port_id minus the base of
    // whichever channel hit.
    logic [SPAN_LOG2-1:0] w_off;
    assign w_off = SPAN_LOG2'(port_id) - SPAN_LOG2'(BASE_ADDR);

    // ------------------------------------------------------------------------
    // Read multiplexer
    // ------------------------------------------------------------------------
    logic [DW-1:0] w_rd_mux;
    logic [DW-1:0] w_stat_data;

    // At most one channel hits, so an OR of the gated buses is a clean mux.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_hit[i]) begin
                w_rd_mux = w_rd_mux | ch_rdata[i*DW +: DW];
            end
        end
    end

    logic [7:0] miss_cnt_q;
    logic [7:0] miss_cnt_d;

    assign w_stat_data = DW'(miss_cnt_q);

    // ------------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------------
    logic [DW-1:0]         in_port_q,  in_port_d;
    logic [NCH-1:0]        ch_wr_q,    ch_wr_d;
    logic [NCH-1:0]        ch_rd_q,    ch_rd_d;
    logic [DW-1:0]         ch_wdata_q, ch_wdata_d;
    logic [SPAN_LOG2-1:0]  dir_q,      dir_d;

    // in_port is refreshed every cycle from port_id alone: KCPSM6 presents
    // port_id a cycle ahead of read_strobe, so the data is ready in the
    // strobe cycle.
    always_comb begin
        in_port_d = '0;
        if (w_any_hit) begin
            in_port_d = w_rd_mux;
        end else if (w_is_stat) begin
            in_port_d = w_stat_data;
        end
    end

    always_comb begin
        ch_wr_d    = {NCH{w_wr}} & w_hit;
        ch_rd_d    = {NCH{w_rd}} & w_hit;
        ch_wdata_d = ch_wdata_q;
        dir_d      = dir_q;
        if (w_wr && w_any_hit) begin
            ch_wdata_d = out_port;
        end
        if (w_any_strobe && w_any_hit) begin
            dir_d = w_off;
        end
    end

    // Miss counter: a write to the status address clears it, any other strobe
    // that lands outside every window and off the status address counts once.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (w_wr && w_is_stat) begin
            miss_cnt_d = 8'd0;
        end else if (w_any_strobe && !w_any_hit && !w_is_stat &&
                     (miss_cnt_q != c_MISS_MAX)) begin
            miss_cnt_d = miss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_port_q  <= '0;
            ch_wr_q    <= '0;
            ch_rd_q    <= '0;
            ch_wdata_q <= '0;
            dir_q      <= '0;
            miss_cnt_q <= 8'd0;
        end else begin
            in_port_q  <= in_port_d;
            ch_wr_q    <= ch_wr_d;
            ch_rd_q    <= ch_rd_d;
            ch_wdata_q <= ch_wdata_d;
            dir_q      <= dir_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign in_port  = in_port_q;
    assign ch_wr    = ch_wr_q;
    assign ch_rd    = ch_rd_q;
    assign ch_wdata = ch_wdata_q;
    assign dir      = dir_q;
    assign miss_cnt = miss_cnt_q;

    // ------------------------------------------------------------------------
    // Per-channel activity hold
    // ------------------------------------------------------------------------
    // The state register moves on the same edge as the strobe registers, so
    // act rises together with ch_wr/ch_rd. Loading ACT_HOLD-1 and leaving
    // when the counter is already 0 keeps act high for exactly ACT_HOLD
    // cycles after the last hit.
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    for (genvar gc = 0; gc < NCH; gc++) begin : g_act
        logic [0:0] st_q,  st_d;
        logic [7:0] cnt_q, cnt_d;
        logic       w_touch;
        logic       w_act_ch;

        assign w_touch = w_any_strobe & w_hit[gc];

        // State register
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                st_q  <= c_ST_IDLE;
                cnt_q <= 8'd0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
            end
        end

        // Next-state logic
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            case (st_q)
                c_ST_IDLE: begin
                    if (w_touch) begin
                        st_d  = c_ST_HOLD;
                        cnt_d = c_HOLD_LD;
                    end
                end
                c_ST_HOLD: begin
                    if (w_touch) begin
                        cnt_d = c_HOLD_LD;
                    end else if (cnt_q == 8'd0) begin
                        st_d = c_ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    st_d  = c_ST_IDLE;
                    cnt_d = 8'd0;
                end
            endcase
        end

        // Output logic
        always_comb begin
            w_act_ch = 1'b0;
            if (st_q == c_ST_HOLD) begin
                w_act_ch = 1'b1;
            end
        end

        assign act[gc] = w_act_ch;
    end

endmodule
`default_nettype wire

// File: doc/io_port_decoder.md
# io_port_decoder

Parametrised port-address decoder and read multiplexer between the KCPSM6 microcontroller port bus and NCH peripheral channels (RTC, VGA, keyboard, sound, and future channels). It generalises the fixed four-channel decode in the micro wrapper. It adds:

- registered per-channel strobes and held activity flags;
- a programmable activity-hold counter;
- a saturating counter of unmapped accesses, readable through a status port.

It sits directly between the KCPSM6 instance and the peripheral controllers.

## Interface

**Parameters**

- DW, 8: data width of out_port, in_port and each channel read bus.
- AW, 8: port_id width.
- NCH, 4: number of channels (1..16).
- SPAN_LOG2, 4: each channel owns 2^SPAN_LOG2 consecutive port addresses.
- BASE_ADDR, 8'h00: first address of channel 0.
- STAT_ADDR, 8'hFF: address of the miss-counter status register. It must lie outside all channel windows.
- ACT_HOLD, 4: number of cycles act[i] stays high after the last access to channel i (1..255).

**Ports**

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- port_id  in  AW  KCPSM6 port address.
- out_port  in  DW  KCPSM6 write data.
- write_strobe  in  1  KCPSM6 write strobe, one cycle.
- read_strobe  in  1  KCPSM6 read strobe, one cycle.
- in_port  out  DW  read data to KCPSM6.
- ch_rdata  in  NCH*DW  channel read buses; channel i occupies [i*DW +: DW].
- ch_wr  out  NCH  registered one-cycle write pulse per channel.
- ch_rd  out  NCH  registered one-cycle read pulse per channel.
- ch_wdata  out  DW  registered copy of out_port, captured on any mapped write.
- dir  out  SPAN_LOG2  registered local offset, port_id − BASE_ADDR − i*2^SPAN_LOG2.
- act  out  NCH  activity flag per channel (actRTC, actVGA, actTeclado, actsonido equivalents).
- miss_cnt  out  8  saturating count of unmapped accesses.

## Operation

**Decode**

- Channel i is hit when BASE_ADDR + i*2^SPAN_LOG2 ≤ port_id < BASE_ADDR + (i+1)*2^SPAN_LOG2.
- Address arithmetic is done in AW+1 bits, so windows never wrap past 2^AW.
- A window truncated by 2^AW simply ends at 2^AW−1.
- At most one channel hits on any cycle.
- An access is unmapped when a strobe is high, no channel hits, and port_id ≠ STAT_ADDR.

**Read path**

- in_port is registered every cycle from port_id, with no strobe needed, because KCPSM6 holds port_id one cycle before read_strobe.
  - hit on channel i → ch_rdata[i];
  - port_id == STAT_ADDR → miss_cnt zero-extended or truncated to DW;
  - otherwise → 0.

**Strobes**

- ch_wr[i] goes high for exactly one cycle, one cycle after a write_strobe that hits channel i. ch_wdata and dir are updated in that same cycle.
- ch_rd[i] follows the same rule for read_strobe. dir is updated on a read as well.
- A write to STAT_ADDR clears miss_cnt to 0. A read from STAT_ADDR has no side effect.

**Activity hold (per channel, independent)**

- States: IDLE (act=0) and HOLD (act=1). A down-counter of width 8 is used.
- IDLE→HOLD on any hit (read or write): counter loaded with ACT_HOLD−1, act=1 in the same cycle as ch_wr/ch_rd.
- HOLD, new hit: counter reloaded (retrigger).
- HOLD, counter==0, no hit: go to IDLE.
- Result: act stays high for exactly ACT_HOLD cycles after the last hit.

**Miss counter**

- Increments once per unmapped strobe and saturates at 255.
- A clear and an increment in the same cycle cannot happen, since KCPSM6 strobes are mutually exclusive.
- If both strobes are asserted together, the write takes priority and the read is ignored.

## Timing

- Reset (async assert, sync-released by the top level): in_port=0, ch_wr=0, ch_rd=0, ch_wdata=0, dir=0, act=0, miss_cnt=0, all channels IDLE.
- Reset asserted mid-hold forces act=0 immediately.
- Strobe-to-pulse latency: 1 cycle. Pulse width: 1 cycle.
- port_id-to-in_port latency: 1 cycle. in_port is valid in the read_strobe cycle provided port_id was stable the cycle before.
- Back-to-back writes to different channels on consecutive cycles produce consecutive one-cycle pulses on the respective ch_wr bits. Each act starts its own hold.

## Test plan

All scenarios use default parameters.

1. **Reset mid-operation:** reset_n low for 3 cycles, then high, with the strobes toggling during reset → all outputs 0 throughout reset; no ch_wr pulse until the first strobe after release.
2. **Mapped write:** write 8'hA5 to port 8'h23 → one cycle later ch_wr=4'b0100, ch_wdata=8'hA5, dir=4'h3, act[2]=1 for exactly 4 cycles.
3. **Mapped read:** ch_rdata={8'h44,8'h33,8'h22,8'h11}, port_id=8'h31 held 1 cycle, then read_strobe → in_port=8'h44 in the strobe cycle; ch_rd=4'b1000 one cycle later.
4. **Retrigger:** writes to 8'h05 at cycles 0 and 2 → act[0] high from cycle 1 through cycle 6 (4 cycles after the second pulse), then low.
5. **Miss counter:** 300 reads from 8'h80 → miss_cnt saturates at 255; read STAT_ADDR returns 8'hFF; write STAT_ADDR → miss_cnt=0 next cycle; no ch_rd/ch_wr/act activity throughout.
6. **Simultaneous strobes:** write_strobe and read_strobe both high at port 8'h12 → only ch_wr[1] pulses; ch_rd stays 0.
